// File: rtl/sr_icache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_icache_pkg : FSM encoding and saturating-counter helper for sr_icache
// Revision      : 1.0
// ---------------------------------------------------------------------------
package sr_icache_pkg;

  typedef enum logic [1:0] {
    ICACHE_IDLE   = 2'd0,
    ICACHE_LOOKUP = 2'd1,
    ICACHE_REFILL = 2'd2
  } icache_state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_icache_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_icache_ram : 1W/1R data array with registered, write-first read port
// Revision      : 1.0
// ---------------------------------------------------------------------------
module sr_icache_ram #(
  parameter int DEPTH = 64,
  parameter int ABITS = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // The final refill word is written in the same cycle the LOOKUP read is
  // issued, so a same-address write must bypass into the read register.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/sr_icache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_icache : direct-mapped read-only instruction cache with line refill
// Revision  : 1.0
// ---------------------------------------------------------------------------
module sr_icache
  import sr_icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int AW    = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          im_req,
  input  logic [AW-1:0] imAddr,
  output logic [31:0]   imData,
  output logic          im_drdy,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rvalid,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
);

  localparam int OFFW = $clog2(WORDS);
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = AW - OFFW - IDXW;
  localparam int RAMW = OFFW + IDXW;

  icache_state_t state, state_nxt;

  logic [AW-1:0]   req_addr;
  logic [OFFW-1:0] cnt;
  logic [OFFW-1:0] cnt_inc;
  logic [LINES-1:0] valid;
  logic [TAGW-1:0] tags [LINES];
  logic [31:0]     held_data;
  logic [31:0]     ram_rdata;

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic            hit;
  logic            latch, miss, fill_wr, fill_last;
  logic [RAMW-1:0] ram_raddr;

  assign req_idx = req_addr[OFFW +: IDXW];
  assign req_tag = req_addr[AW-1 -: TAGW];
  assign hit     = valid[req_idx] && (tags[req_idx] == req_tag);
  assign cnt_inc = cnt + OFFW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= ICACHE_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    im_drdy   = 1'b0;
    latch     = 1'b0;
    miss      = 1'b0;
    fill_wr   = 1'b0;
    fill_last = 1'b0;
    case (state)
      ICACHE_IDLE: begin
        if (im_req) begin
          latch     = 1'b1;
          state_nxt = ICACHE_LOOKUP;
        end
      end
      ICACHE_LOOKUP: begin
        if (hit) begin
          im_drdy = 1'b1;
          if (im_req) latch = 1'b1;
          else        state_nxt = ICACHE_IDLE;
        end else begin
          miss      = 1'b1;
          state_nxt = ICACHE_REFILL;
        end
      end
      ICACHE_REFILL: begin
        if (mem_rvalid) begin
          fill_wr = 1'b1;
          if (&cnt) begin
            fill_last = 1'b1;
            state_nxt = ICACHE_LOOKUP;
          end
        end
      end
      default: state_nxt = ICACHE_IDLE;
    endcase
  end

  // Read with the incoming address when a request is accepted, so the data
  // is already registered in the LOOKUP cycle that follows.
  assign ram_raddr = latch ? imAddr[RAMW-1:0] : req_addr[RAMW-1:0];

  sr_icache_ram #(
    .DEPTH (LINES * WORDS),
    .ABITS (RAMW)
  ) u_ram (
    .clk   (clk),
    .we    (fill_wr),
    .waddr ({req_idx, cnt}),
    .wdata (mem_rdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign imData = im_drdy ? ram_rdata : held_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      held_data <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (latch)   req_addr  <= imAddr;
      if (im_drdy) begin
        held_data <= ram_rdata;
        hit_cnt   <= sat_inc(hit_cnt);
      end
      if (miss)    miss_cnt  <= sat_inc(miss_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cnt      <= '0;
    end else if (miss) begin
      mem_req  <= 1'b1;
      mem_addr <= {req_addr[AW-1:OFFW], {OFFW{1'b0}}};
      cnt      <= '0;
    end else if (fill_wr) begin
      cnt      <= cnt_inc;
      mem_addr <= {req_addr[AW-1:OFFW], cnt_inc};
      if (fill_last) mem_req <= 1'b0;
    end
  end

  // Flush wins over the valid set of a completing refill.
  always_ff @(posedge clk) begin
    if (rst || flush)   valid <= '0;
    else if (fill_last) valid[req_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_last) tags[req_idx] <= req_tag;
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_icache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sr_icache : directed + random fetches checked against a line-level model
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_sr_icache;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst, im_req, flush, mem_rvalid;
  logic [AW-1:0] imAddr;
  logic [31:0]   imData, mem_rdata, hit_cnt, miss_cnt;
  logic          im_drdy, mem_req;
  logic [AW-1:0] mem_addr;

  sr_icache #(.LINES(16), .WORDS(4), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .im_req     (im_req),
    .imAddr     (imAddr),
    .imData     (imData),
    .im_drdy    (im_drdy),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: which line address each index holds, plus counters and last output.
  logic [15:0] m_valid;
  logic [23:0] m_tag [16];
  logic [31:0] m_hit, m_miss, m_last;
  int          lat_fix;

  function automatic logic [31:0] backing(input logic [AW-1:0] a);
    if (a < 4) return 32'h11 * (32'(a) + 32'd1);
    return {a[15:0], ~a[15:0]} ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = '0;
    m_hit   = '0;
    m_miss  = '0;
    m_last  = '0;
  endtask

  // Idle cycles; optional flush on the first one (possibly during a hit cycle)
  // and optional stray rvalid that must be ignored.
  task automatic tick(input int n, input bit fl, input bit stray);
    for (int i = 0; i < n; i++) begin
      flush      = fl && (i == 0);
      mem_rvalid = stray;
      mem_rdata  = $urandom;
      if (flush) m_valid = '0;
      cyc();
      flush      = 1'b0;
      mem_rvalid = 1'b0;
      check("idle_drdy", {31'b0, im_drdy}, 32'd0);
      check("idle_hold", imData, m_last);
      check("idle_memreq", {31'b0, mem_req}, 32'd0);
    end
  endtask

  // Starts at a negedge where the cache is idle or delivering; ends at the
  // negedge of the cycle that delivers addr a (or after an aborting reset).
  task automatic fetch(input logic [AW-1:0] a, input bit fl_last, input int abort_after);
    int idx;
    logic [23:0] tag;
    bit flushed;
    idx = int'(a[5:2]);
    tag = a[29:6];
    im_req = 1'b1;
    imAddr = a;
    cyc();
    im_req = 1'b0;
    imAddr = AW'($urandom);
    for (int tries = 0; tries < 3; tries++) begin
      if (m_valid[idx] && m_tag[idx] == tag) begin
        check("hit_drdy", {31'b0, im_drdy}, 32'd1);
        check("hit_data", imData, backing(a));
        check("hit_memreq", {31'b0, mem_req}, 32'd0);
        check("hit_cnt", hit_cnt, m_hit);
        check("miss_cnt", miss_cnt, m_miss);
        m_hit++;
        m_last = backing(a);
        return;
      end
      check("miss_drdy", {31'b0, im_drdy}, 32'd0);
      check("miss_cnt_pre", miss_cnt, m_miss);
      m_miss++;
      flushed = 1'b0;
      cyc();
      for (int w = 0; w < 4; w++) begin
        int lat;
        logic [AW-1:0] wa;
        wa  = {a[AW-1:2], 2'(w)};
        lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        for (int l = 0; l < lat; l++) begin
          check("refill_wait_req", {31'b0, mem_req}, 32'd1);
          check("refill_wait_addr", 32'(mem_addr), 32'(wa));
          cyc();
        end
        check("refill_req", {31'b0, mem_req}, 32'd1);
        check("refill_addr", 32'(mem_addr), 32'(wa));
        mem_rvalid = 1'b1;
        mem_rdata  = backing(wa);
        if (fl_last && w == 3 && tries == 0) begin
          flush   = 1'b1;
          flushed = 1'b1;
        end
        cyc();
        mem_rvalid = 1'b0;
        flush      = 1'b0;
        mem_rdata  = $urandom;
        if (abort_after == w + 1) begin
          rst = 1'b1;
          cyc();
          rst = 1'b0;
          model_reset();
          check("abort_memreq", {31'b0, mem_req}, 32'd0);
          check("abort_drdy", {31'b0, im_drdy}, 32'd0);
          check("abort_miss_cnt", miss_cnt, 32'd0);
          check("abort_data", imData, 32'd0);
          return;
        end
      end
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      if (flushed) m_valid = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; im_req = 1'b0; imAddr = '0; flush = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; lat_fix = 2;
    model_reset();
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    check("rst_drdy", {31'b0, im_drdy}, 32'd0);
    check("rst_data", imData, 32'd0);
    check("rst_memreq", {31'b0, mem_req}, 32'd0);
    check("rst_memaddr", 32'(mem_addr), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);

    // Cold miss, then back-to-back hits on the same line.
    fetch(30'd0, 1'b0, 0);
    fetch(30'd1, 1'b0, 0);
    fetch(30'd2, 1'b0, 0);
    fetch(30'd3, 1'b0, 0);
    tick(3, 1'b0, 1'b0);
    check("hits_after_line0", hit_cnt, 32'd4);
    check("misses_after_line0", miss_cnt, 32'd1);

    // Conflict eviction on index 0.
    fetch(30'd64, 1'b0, 0);
    tick(1, 1'b0, 1'b1);
    fetch(30'd0, 1'b0, 0);
    tick(1, 1'b0, 0);
    check("misses_after_conflict", miss_cnt, 32'd3);

    // Flush in idle, then flush during a hit cycle, then flush on final rvalid.
    tick(1, 1'b1, 1'b0);
    fetch(30'd1, 1'b0, 0);
    fetch(30'd2, 1'b0, 0);
    tick(1, 1'b1, 1'b0);
    fetch(30'd3, 1'b0, 0);
    fetch(30'd65, 1'b1, 0);
    tick(1, 1'b0, 1'b0);
    check("misses_after_flushes", miss_cnt, 32'd7);

    // Reset after two of four rvalids, then full refill of addr 0.
    fetch(30'd0, 1'b0, 2);
    fetch(30'd0, 1'b0, 0);
    tick(2, 1'b0, 1'b0);
    check("post_abort_miss", miss_cnt, 32'd1);

    // Randomized traffic over a few conflicting lines.
    lat_fix = -1;
    for (int it = 0; it < 80; it++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 2) * 64 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      fetch(a, $urandom_range(0, 15) == 0, 0);
      if ($urandom_range(0, 2) == 0)
        tick(int'($urandom_range(1, 2)), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    tick(1, 1'b0, 1'b0);
    check("final_hit_cnt", hit_cnt, m_hit);
    check("final_miss_cnt", miss_cnt, m_miss);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
